// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
// Build option: define PC_RVC_EN for compressed (16-bit) instruction support.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam int unsigned PC_INC_32 = 32'd4;
    localparam int unsigned PC_INC_16 = 32'd2;

    localparam logic [31:0] PC_RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VECTOR_DEF  = 32'h0000_0100;

endpackage

// File: rtl/pc_sequencer.sv
// Program counter with trap / trap-return / redirect / sequential next-PC priority.
// Build option: PC_RVC_EN enables 2-byte increments and 2-byte redirect alignment.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(PC_TRAP_VECTOR_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_update,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            inst_compressed,
    input  logic            trap_req,
    input  logic            mret_req,
    output logic [XLEN-1:0] current_pc,
    output logic [XLEN-1:0] pc_next_seq,
    output logic [XLEN-1:0] epc,
    output logic            misaligned_exc,
    output logic            halted
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            exc_q, exc_d;
    logic            halted_q, halted_d;

    logic [XLEN-1:0] inc_s;
    logic [XLEN-1:0] target_s;
    logic            misalign_s;

    // Bit 0 of a redirect target is always discarded (JALR semantics).
    assign target_s = redirect_target & ~(XLEN'(1));

`ifdef PC_RVC_EN
    assign inc_s      = inst_compressed ? XLEN'(PC_INC_16) : XLEN'(PC_INC_32);
    assign misalign_s = 1'b0;
`else
    logic unused_compressed_s;
    assign unused_compressed_s = inst_compressed;
    assign inc_s               = XLEN'(PC_INC_32);
    assign misalign_s          = target_s[1];
`endif

    assign pc_next_seq = pc_q + inc_s;

    // Next-state priority mux for PC, epc, state and flags.
    always_comb begin
        pc_d     = pc_q;
        epc_d    = epc_q;
        state_d  = state_q;
        exc_d    = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (trap_req) begin
                    epc_d = pc_q;
                    pc_d  = TRAP_VECTOR;
                end else if (mret_req) begin
                    pc_d = epc_q;
                end else if (pc_update && redirect_valid) begin
                    if (misalign_s) begin
                        epc_d   = pc_q;
                        exc_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d = target_s;
                    end
                end else if (pc_update) begin
                    pc_d = pc_next_seq;
                end else begin
                    pc_d = pc_q;
                end
            end
            HALT: begin
                // The faulting PC in epc is kept across the trap entry.
                if (trap_req) begin
                    pc_d    = TRAP_VECTOR;
                    state_d = RUN;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                pc_d    = RESET_VECTOR;
                state_d = BOOT;
            end
        endcase
        halted_d = (state_d == HALT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_VECTOR;
            epc_q    <= '0;
            exc_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            exc_q    <= exc_d;
            halted_q <= halted_d;
        end
    end

    assign current_pc     = pc_q;
    assign epc            = epc_q;
    assign misaligned_exc = exc_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random traffic
// against a behavioural model of the PC rules.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_update;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_compressed;
    logic        trap_req;
    logic        mret_req;
    logic [31:0] current_pc;
    logic [31:0] pc_next_seq;
    logic [31:0] epc;
    logic        misaligned_exc;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_halt;
    logic        m_boot;
    logic        m_exc;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .pc_update       (pc_update),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_compressed (inst_compressed),
        .trap_req        (trap_req),
        .mret_req        (mret_req),
        .current_pc      (current_pc),
        .pc_next_seq     (pc_next_seq),
        .epc             (epc),
        .misaligned_exc  (misaligned_exc),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] step_size(input logic ic);
`ifdef PC_RVC_EN
        return ic ? 32'd2 : 32'd4;
`else
        return 32'd4;
`endif
    endfunction

    function automatic logic is_misaligned(input logic [31:0] t);
`ifdef PC_RVC_EN
        return 1'b0;
`else
        return (t % 32'd4) != 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, clock, and compare everything.
    task automatic cyc(input logic rst, input logic pu, input logic rv,
                       input logic [31:0] tgt, input logic ic,
                       input logic tr, input logic mr);
        logic [31:0] t;
        reset           = rst;
        pc_update       = pu;
        redirect_valid  = rv;
        redirect_target = tgt;
        inst_compressed = ic;
        trap_req        = tr;
        mret_req        = mr;
        m_exc = 1'b0;
        if (rst) begin
            m_pc = 32'h0; m_epc = 32'h0; m_halt = 1'b0; m_boot = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
            if (tr) begin
                m_pc = 32'h100; m_halt = 1'b0;
            end
        end else if (tr) begin
            m_epc = m_pc; m_pc = 32'h100;
        end else if (mr) begin
            m_pc = m_epc;
        end else if (pu && rv) begin
            t = tgt - (tgt % 32'd2);
            if (is_misaligned(t)) begin
                m_epc = m_pc; m_exc = 1'b1; m_halt = 1'b1;
            end else begin
                m_pc = t;
            end
        end else if (pu) begin
            m_pc = m_pc + step_size(ic);
        end
        @(posedge clk);
        #1;
        chk("current_pc", current_pc, m_pc);
        chk("epc", epc, m_epc);
        chk("misaligned_exc", {31'd0, misaligned_exc}, {31'd0, m_exc});
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
        chk("pc_next_seq", pc_next_seq, m_pc + step_size(ic));
    endtask

    initial begin
        m_pc = 32'h0; m_epc = 32'h0; m_halt = 1'b0; m_boot = 1'b1; m_exc = 1'b0;
        // 1. reset for two cycles, then BOOT ignores pc_update
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_pc", current_pc, 32'h0);
        chk("reset_epc", epc, 32'h0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("boot_ignore", current_pc, 32'h0);
        // 2. sequential steps then hold
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("seq_4", current_pc, 32'h4);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("seq_8", current_pc, 32'h8);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("seq_c", current_pc, 32'hC);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("hold_c", current_pc, 32'hC);
        // redirect without pc_update is ignored
        cyc(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        chk("redir_no_update", current_pc, 32'hC);
        // 3. redirect with bit0 cleared, then a misaligned target
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("seq_10", current_pc, 32'h10);
        cyc(1'b0, 1'b1, 1'b1, 32'h41, 1'b0, 1'b0, 1'b0);
        chk("redir_41", current_pc, 32'h40);
        cyc(1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h42, 1'b0, 1'b0, 1'b0);
`ifndef PC_RVC_EN
        chk("mis_pc", current_pc, 32'h10);
        chk("mis_epc", epc, 32'h10);
        chk("mis_exc", {31'd0, misaligned_exc}, 32'd1);
        chk("mis_halted", {31'd0, halted}, 32'd1);
`else
        chk("rvc_redir_42", current_pc, 32'h42);
        chk("rvc_no_exc", {31'd0, misaligned_exc}, 32'd0);
`endif
        // redirect stays high; pulse must drop, HALT ignores mret/redirect
        cyc(1'b0, 1'b1, 1'b1, 32'h42, 1'b0, 1'b0, 1'b1);
`ifndef PC_RVC_EN
        chk("exc_pulse_drop", {31'd0, misaligned_exc}, 32'd0);
        chk("halt_hold_pc", current_pc, 32'h10);
`endif
        // 4. trap from HALT, then return
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("trap_pc", current_pc, 32'h100);
        chk("trap_halted", {31'd0, halted}, 32'd0);
`ifndef PC_RVC_EN
        chk("trap_epc_kept", epc, 32'h10);
`endif
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
`ifndef PC_RVC_EN
        chk("mret_pc", current_pc, 32'h10);
`endif
        // 5. priority: trap beats mret and redirect
        cyc(1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 1'b1);
        chk("prio_pc", current_pc, 32'h100);
        chk("prio_epc", epc, 32'h20);
        // mret beats redirect
        cyc(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
        chk("mret_prio", current_pc, 32'h20);
        // wrap-around
        cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        chk("wrap_next", pc_next_seq, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("wrap_pc", current_pc, 32'h0);
`ifdef PC_RVC_EN
        // 6. compressed increment
        cyc(1'b0, 1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("rvc_inc", current_pc, 32'hA);
`endif
        // reset wins in HALT
        cyc(1'b0, 1'b1, 1'b1, 32'h6, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("reset_in_halt_pc", current_pc, 32'h0);
        chk("reset_in_halt_h", {31'd0, halted}, 32'd0);
        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            tgt = $urandom();
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 9) < 3),
                tgt,
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 15) == 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
